// File: rtl/fix_field_stream_if.sv
// fix_field_stream_if: byte-stream input and field-FIFO output bus of the FIX
// field extractor.
//   data_i / data_valid_i / data_ready_o : input byte handshake
//   fld_valid_o / fld_ready_i            : field FIFO head handshake
//   fld_tag_o, fld_value_o, fld_len_o,
//   fld_trunc_o, fld_som_o, fld_eom_o,
//   fld_chk_err_o                        : FIFO head payload
// slave = extractor side, master = byte source / field consumer side.
interface fix_field_stream_if #(
   parameter int unsigned TAG_WIDTH = 32,
   parameter int unsigned VAL_BYTES = 32
);
   localparam int unsigned LEN_W = $clog2(VAL_BYTES + 1);

   logic [7:0]             data_i;
   logic                   data_valid_i;
   logic                   data_ready_o;
   logic                   fld_valid_o;
   logic                   fld_ready_i;
   logic [TAG_WIDTH-1:0]   fld_tag_o;
   logic [8*VAL_BYTES-1:0] fld_value_o;
   logic [LEN_W-1:0]       fld_len_o;
   logic                   fld_trunc_o;
   logic                   fld_som_o;
   logic                   fld_eom_o;
   logic                   fld_chk_err_o;

   modport slave (
      input  data_i, data_valid_i, fld_ready_i,
      output data_ready_o, fld_valid_o, fld_tag_o, fld_value_o, fld_len_o,
             fld_trunc_o, fld_som_o, fld_eom_o, fld_chk_err_o
   );

   modport master (
      output data_i, data_valid_i, fld_ready_i,
      input  data_ready_o, fld_valid_o, fld_tag_o, fld_value_o, fld_len_o,
             fld_trunc_o, fld_som_o, fld_eom_o, fld_chk_err_o
   );
endinterface

// File: rtl/fix_field_stream.sv
// fix_field_stream: splits a FIX byte stream into "tag=value<SOH>" fields,
// converts the ASCII tag to binary, packs value bytes, verifies the tag-10
// checksum and buffers complete fields in a first-word-fall-through FIFO.
//   clk, rst           : clock, synchronous active-low reset
//   bus (slave)        : byte input handshake and field FIFO head
//   start_of_header_o  : pulse, tag-8 field pushed
//   end_of_body_o      : pulse, tag-10 field pushed
//   err_o              : pulse, malformed field dropped
//   level_o            : FIFO occupancy
//   empty_o / full_o   : FIFO status
module fix_field_stream #(
   parameter int unsigned TAG_WIDTH  = 32,
   parameter int unsigned TAG_DIGITS = 9,
   parameter int unsigned VAL_BYTES  = 32,
   parameter int unsigned DEPTH      = 16,
   parameter logic [7:0]  SOH_CHAR   = 8'h01
) (
   input  logic                       clk,
   input  logic                       rst,
   fix_field_stream_if.slave          bus,
   output logic                       start_of_header_o,
   output logic                       end_of_body_o,
   output logic                       err_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       empty_o,
   output logic                       full_o
);
   localparam int unsigned LEN_W = $clog2(VAL_BYTES + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam int unsigned DIG_W = $clog2(TAG_DIGITS + 1);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(VAL_BYTES);
   localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(TAG_DIGITS);
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

   typedef enum logic [1:0] {S_TAG, S_VALUE, S_DROP} state_e;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]   tag;
      logic [8*VAL_BYTES-1:0] val;
      logic [LEN_W-1:0]       len;
      logic                   trunc;
      logic                   som;
      logic                   eom;
      logic                   chk;
   } entry_t;

   state_e                 state_q, state_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [DIG_W-1:0]       ndig_q, ndig_d;
   logic [8*VAL_BYTES-1:0] val_q, val_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic                   trunc_q, trunc_d;
   logic [9:0]             cn_q, cn_d;      // decimal value of the field's value bytes
   logic                   cok_q, cok_d;    // every value byte so far was a digit
   logic [7:0]             sum_q, sum_d;
   logic [7:0]             fsum_q, fsum_d;
   logic                   fstart_q, fstart_d;
   logic                   sohp_q, sohp_d;
   logic                   eobp_q, eobp_d;
   logic                   errp_q, errp_d;
   logic                   push;

   entry_t                 mem_q [DEPTH];
   entry_t                 ent;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]       level_q;

   logic                   accept, pop, is_soh, is_digit;
   logic [7:0]             b;
   logic [3:0]             dig;

   assign b        = bus.data_i;
   assign is_soh   = (b == SOH_CHAR);
   assign is_digit = (b >= 8'h30) && (b <= 8'h39);
   assign dig      = b[3:0];
   assign full_o   = (level_q == LVL_MAX);
   assign empty_o  = (level_q == '0);
   assign level_o  = level_q;
   assign bus.data_ready_o = !full_o;
   assign accept   = bus.data_valid_i && !full_o;
   assign pop      = bus.fld_ready_i && !empty_o;

   assign start_of_header_o = sohp_q;
   assign end_of_body_o     = eobp_q;
   assign err_o             = errp_q;

   // Entry assembled from the accumulators as they stand before the SOH
   always_comb begin
      ent       = '0;
      ent.tag   = tag_q;
      ent.val   = val_q;
      ent.len   = len_q;
      ent.trunc = trunc_q;
      ent.som   = (tag_q == TAG_WIDTH'(8));
      ent.eom   = (tag_q == TAG_WIDTH'(10));
      ent.chk   = !cok_q || (int'(len_q) != 3) || trunc_q || (cn_q != {2'b00, fsum_q});
   end

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      ndig_d   = ndig_q;
      val_d    = val_q;
      len_d    = len_q;
      trunc_d  = trunc_q;
      cn_d     = cn_q;
      cok_d    = cok_q;
      sum_d    = sum_q;
      fsum_d   = fsum_q;
      fstart_d = fstart_q;
      sohp_d   = 1'b0;
      eobp_d   = 1'b0;
      errp_d   = 1'b0;
      push     = 1'b0;
      if (accept) begin
         sum_d    = sum_q + b;
         fstart_d = 1'b0;
         if (fstart_q) fsum_d = sum_q;
         case (state_q)
            S_TAG: begin
               if (is_soh) begin
                  errp_d   = 1'b1;
                  fstart_d = 1'b1;
               end else if (is_digit) begin
                  if (ndig_q == DIG_MAX) begin
                     state_d = S_DROP;
                  end else begin
                     tag_d  = tag_q * TAG_WIDTH'(10) + TAG_WIDTH'(dig);
                     ndig_d = ndig_q + DIG_W'(1);
                  end
               end else if ((b == 8'h3D) && (ndig_q != '0)) begin
                  state_d = S_VALUE;
               end else begin
                  state_d = S_DROP;
               end
            end
            S_VALUE: begin
               if (is_soh) begin
                  push     = 1'b1;
                  sohp_d   = ent.som;
                  eobp_d   = ent.eom;
                  fstart_d = 1'b1;
                  state_d  = S_TAG;
                  // A checksum field closes the message: next message sums from zero
                  if (ent.eom) sum_d = '0;
               end else begin
                  if (len_q < LEN_MAX) begin
                     val_d[8*len_q +: 8] = b;
                     len_d               = len_q + LEN_W'(1);
                  end else begin
                     trunc_d = 1'b1;
                  end
                  if (!is_digit) cok_d = 1'b0;
                  cn_d = cn_q * 10'd10 + 10'(dig);
               end
            end
            default: begin
               if (is_soh) begin
                  errp_d   = 1'b1;
                  fstart_d = 1'b1;
                  state_d  = S_TAG;
               end
            end
         endcase
         if (fstart_d) begin
            tag_d   = '0;
            ndig_d  = '0;
            val_d   = '0;
            len_d   = '0;
            trunc_d = 1'b0;
            cn_d    = '0;
            cok_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_TAG;
         tag_q    <= '0;
         ndig_q   <= '0;
         val_q    <= '0;
         len_q    <= '0;
         trunc_q  <= 1'b0;
         cn_q     <= '0;
         cok_q    <= 1'b1;
         sum_q    <= '0;
         fsum_q   <= '0;
         fstart_q <= 1'b1;
         sohp_q   <= 1'b0;
         eobp_q   <= 1'b0;
         errp_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         ndig_q   <= ndig_d;
         val_q    <= val_d;
         len_q    <= len_d;
         trunc_q  <= trunc_d;
         cn_q     <= cn_d;
         cok_q    <= cok_d;
         sum_q    <= sum_d;
         fsum_q   <= fsum_d;
         fstart_q <= fstart_d;
         sohp_q   <= sohp_d;
         eobp_q   <= eobp_d;
         errp_q   <= errp_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      level_q <= level_q + LVL_W'(1);
         else if (pop && !push) level_q <= level_q - LVL_W'(1);
      end
   end

   // Payload storage needs no reset; push never targets a full FIFO
   always_ff @(posedge clk) begin
      if (rst && push) mem_q[wr_ptr_q] <= ent;
   end

   assign bus.fld_valid_o   = !empty_o;
   assign bus.fld_tag_o     = mem_q[rd_ptr_q].tag;
   assign bus.fld_value_o   = mem_q[rd_ptr_q].val;
   assign bus.fld_len_o     = mem_q[rd_ptr_q].len;
   assign bus.fld_trunc_o   = mem_q[rd_ptr_q].trunc;
   assign bus.fld_som_o     = mem_q[rd_ptr_q].som;
   assign bus.fld_eom_o     = mem_q[rd_ptr_q].eom;
   assign bus.fld_chk_err_o = mem_q[rd_ptr_q].chk;
endmodule
